sync_ram_ctrl: RTL

//   Parametrised single-port synchronous RAM for the CPU data/instruction store; successor to the fixed 4Kx16 RAM.

---
 rtl/sync_ram_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sync_ram_ctrl.sv
// sync_ram_ctrl: single-port synchronous RAM with byte enables, 1/2-cycle
// read latency, read-valid strobe, address range guard and post-reset clear.
// Ports: clk, rst (sync, active-high); addr/data_in/we/be/re request side;
//   data_out/rd_valid read result; busy while clearing; addr_err bad address.
module sync_ram_ctrl #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 12,
  parameter int DEPTH        = 4096,
  parameter int RD_LAT       = 1,
  parameter bit WRITE_FIRST  = 1'b1,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic                re,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid,
  output logic                busy,
  output logic                addr_err
);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_C =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C =
    ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              idle;
  logic              clr_en;
  logic              in_rng;
  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] cur_w;
  logic [DATA_W-1:0] mrg_w;
  logic [DATA_W-1:0] rd_w;

  logic              p_vld_q;
  logic [DATA_W-1:0] p_dat_q;
  logic              vld_q;
  logic [DATA_W-1:0] dout_q;
  logic              err_q;
  logic              fire;
  logic [DATA_W-1:0] fire_w;

  assign idle   = (state_q == S_IDLE) && !rst;
  assign clr_en = (state_q == S_CLEAR) && !rst;
  assign in_rng = {1'b0, addr} < DEPTH_C;
  assign wr_ok  = idle && we && in_rng;
  assign rd_ok  = idle && re;
  assign cur_w  = in_rng ? mem[addr] : '0;

  // Word as it will look after this edge's write.
  always_comb begin
    mrg_w = cur_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) mrg_w[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  // Out-of-range reads return zero; a same-edge
  // write is visible only in write-first mode.
  assign rd_w = !in_rng ? '0 :
                (WRITE_FIRST && we) ? mrg_w : cur_w;

  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_ok) begin
      mem[addr] <= mrg_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR_ON_RST ? S_CLEAR : S_IDLE;
      clr_cnt_q <= '0;
    end else if (state_q == S_CLEAR) begin
      clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
      if (clr_cnt_q == LAST_C) state_q <= S_IDLE;
    end
  end

  // Latency 2 inserts one pipeline register
  // ahead of the output register.
  always_comb begin
    if (RD_LAT == 2) begin
      fire   = p_vld_q;
      fire_w = p_dat_q;
    end else begin
      fire   = rd_ok;
      fire_w = rd_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_vld_q <= 1'b0;
      p_dat_q <= '0;
      vld_q   <= 1'b0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      p_vld_q <= rd_ok;
      if (rd_ok) p_dat_q <= rd_w;
      vld_q <= fire;
      if (fire) dout_q <= fire_w;
      err_q <= idle && (we || re) && !in_rng;
    end
  end

  assign data_out = dout_q;
  assign rd_valid = vld_q;
  assign busy     = (state_q == S_CLEAR);
  assign addr_err = err_q;

endmodule
